vote_logger: RTL
================

Name: vote_logger

Overview:
- Voting-side counterpart of the count display path: it writes the per-candidate vote tallies, and the display logic reads them back out.
- In voting mode (mode=0), each button press with exactly one candidate selected adds one to that candidate's counter.
- Counters drive the vote_count_1..4 buses consumed by the display/result logic.
- One vote per press: a press-release lockout stops repeat counting while the button is held.

Parameters:
- CNT_W, 8, width of each candidate counter and vote_count_N output.
- LOCK_CYCLES, 4, idle cycles enforced after release before the next press is accepted (0 = none).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset_all  input  1  asynchronous active-low reset; clears all counters and state.
- mode  input  1  0 = voting (counting enabled), 1 = result/display mode (no counting).
- button  input  1  vote button, level, already synchronous to clk.
- candidate  input  4  one-hot candidate select; bit0 = candidate 1 ... bit3 = candidate 4.
- vote_count_1  output  CNT_W  tally for candidate 1; vote_count_2..vote_count_4 are identical for candidates 2..4.
- vote_ack  output  1  one-cycle pulse: a vote was committed.
- vote_err  output  1  one-cycle pulse: press rejected (candidate not one-hot).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset_all=0, async): vote_count_1..4=0, vote_ack=0, vote_err=0, busy=0, state=IDLE, button_q=0, lock counter=0.
- button_q is button registered; press event = button & ~button_q.
- FSM states: IDLE, COMMIT, REJECT, HOLD, LOCK.
- IDLE: on a press event with mode=0:
  - candidate one-hot → latch candidate into cand_q, go to COMMIT.
  - otherwise (0000 or multiple bits) → go to REJECT.
  - Press events with mode=1 are ignored; state stays IDLE.
- COMMIT (1 cycle): increment the counter selected by cand_q; assert vote_ack for the cycle after this edge; go to HOLD.
- REJECT (1 cycle): no counter change; assert vote_err; go to HOLD.
- HOLD: stay until button=0 AND candidate=0000 sampled together.
  - Then go to LOCK with lock counter loaded with LOCK_CYCLES-1.
  - If LOCK_CYCLES=0, go directly to IDLE.
- LOCK: count down once per cycle; at 0 go to IDLE. Inputs are ignored, so a press during LOCK is lost (not queued).
- Latency: button first sampled high at edge k → COMMIT entered at edge k → counter and vote_ack update at edge k+1.
- mode is sampled only in IDLE. A mode change during COMMIT/REJECT/HOLD/LOCK does not abort the sequence: the latched vote still commits.
- candidate changing after the press is ignored (cand_q is used).
- Counters and the pulse outputs (vote_ack, vote_err) are registered; busy is registered (decoded from state).
- Reset asserted mid-sequence: immediate return to reset values; a pending COMMIT is discarded.
- Overflow: see optional feature.

Optional Feature:
- Macro VOTE_SAT_EN.
- Defined: a counter at 2^CNT_W-1 holds its value. vote_ack still pulses, and vote_err also pulses in the same cycle to flag saturation.
- Undefined: the counter wraps modulo 2^CNT_W (255 → 0 for CNT_W=8) with vote_ack only.

Test Plan:
- Reset → all vote_count_N=0, busy=0. Then mode=0, candidate=0010, button high 5 cycles, release both → vote_count_2=1, others 0, exactly one vote_ack pulse.
- Hold button high 50 cycles with candidate=0001 → vote_count_1 increments by exactly 1; busy=1 until LOCK_CYCLES=4 cycles after release.
- candidate=0101, press → vote_err one pulse, all counts unchanged. Also candidate=0000, press → vote_err, no change.
- mode=1, candidate=1000, press → no count, no ack, busy stays 0. Then switch mode to 1 one cycle after a valid press with candidate=0100 → vote_count_3 still increments.
- Drive vote_count_4 to 255 via 255 presses, then one more press → VOTE_SAT_EN: stays 255 with vote_ack and vote_err; without: wraps to 0, vote_ack only.
- Assert reset_all low while in COMMIT (edge k) → at edge k+1 counters remain 0, no vote_ack, state IDLE, busy=0.

Source files
------------

// File: rtl/vote_logger.sv
// Vote tally writer: one committed vote per button press, with a press-release lockout.
// Optional macro VOTE_SAT_EN: counters saturate at all-ones (flagged by vote_err) instead of wrapping.
module vote_logger #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned LOCK_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_all,
    input  logic             mode,
    input  logic             button,
    input  logic [3:0]       candidate,
    output logic [CNT_W-1:0] vote_count_1,
    output logic [CNT_W-1:0] vote_count_2,
    output logic [CNT_W-1:0] vote_count_3,
    output logic [CNT_W-1:0] vote_count_4,
    output logic             vote_ack,
    output logic             vote_err,
    output logic             busy
);

    localparam int unsigned LCK_W   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int unsigned N_CAND  = 4;
    localparam int unsigned LCK_INI = (LOCK_CYCLES == 0) ? 0 : LOCK_CYCLES - 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_COMMIT = 3'd1;
    localparam logic [2:0] S_REJECT = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_LOCK   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             button_q;
    logic [3:0]       cand_q, cand_d;
    logic [LCK_W-1:0] lock_q, lock_d;
    logic [CNT_W-1:0] cnt_q [N_CAND];
    logic [CNT_W-1:0] cnt_d [N_CAND];
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             press_c;

    assign press_c = button & ~button_q;

    // Next-state, counter update and pulse generation
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press_c && !mode) begin
                    if ($onehot(candidate)) begin
                        cand_d  = candidate;
                        state_d = S_COMMIT;
                    end else begin
                        state_d = S_REJECT;
                    end
                end
            end
            S_COMMIT: begin
                ack_d   = 1'b1;
                state_d = S_HOLD;
                for (int i = 0; i < N_CAND; i++) begin
                    if (cand_q[i]) begin
`ifdef VOTE_SAT_EN
                        if (cnt_q[i] == {CNT_W{1'b1}}) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
`else
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
`endif
                    end
                end
            end
            S_REJECT: begin
                err_d   = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // Release means both the button and the selection are cleared.
                if (!button && (candidate == 4'b0000)) begin
                    if (LOCK_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOCK;
                        lock_d  = LCK_W'(LCK_INI);
                    end
                end
            end
            S_LOCK: begin
                if (lock_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    lock_d = lock_q - LCK_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_all) begin
        if (!reset_all) begin
            state_q  <= S_IDLE;
            button_q <= 1'b0;
            cand_q   <= 4'b0000;
            lock_q   <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i < N_CAND; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            button_q <= button;
            cand_q   <= cand_d;
            lock_q   <= lock_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            for (int i = 0; i < N_CAND; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign vote_count_1 = cnt_q[0];
    assign vote_count_2 = cnt_q[1];
    assign vote_count_3 = cnt_q[2];
    assign vote_count_4 = cnt_q[3];
    assign vote_ack     = ack_q;
    assign vote_err     = err_q;
    assign busy         = busy_q;

endmodule
